// File: rtl/acc_seq_pkg.sv
// Shared constants for the ACC/temp phase sequencer and related bus timing.
package acc_seq_pkg;

    // Machine-cycle phases, A1 first.
    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    // Accumulator-class operation codes from the decoder.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LDA   = 3'd1,
        OP_XCH   = 3'd2,
        OP_ALU   = 3'd3,
        OP_ALUNC = 3'd4
    } op_class_e;

    // ALU B-operand source select.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_REG  = 2'd1,
        SRC_TEMP = 2'd2
    } src_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT2 = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    // ALU function that forwards operand B unchanged.
    localparam logic [3:0] FN_PASSB = 4'hB;

endpackage

// File: rtl/acc_temp_sequencer_phase_counter.sv
// Free-running 3-bit machine-phase counter with A1 sync marker.
module phase_counter
    import acc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    output logic [2:0] phase,
    output logic       syncOut
);

    logic running;

    // Hold phase 0 for one clock after reset release, then count and wrap.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase   <= '0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (running)
                phase <= phase + 3'd1;
        end
    end

    assign syncOut = (phase == PH_A1);

endmodule

// File: rtl/acc_temp_sequencer.sv
// Phase sequencer driving ACC/temp register strobes and ALU controls.
module acc_temp_sequencer
    import acc_seq_pkg::*;
#(
    parameter int OPW = 3,
    parameter int FNW = 4
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           opValid,
    input  logic [OPW-1:0] opClass,
    input  logic [FNW-1:0] opFunc,
    input  logic           twoWord,
    output logic           opReady,
    output logic [2:0]     phase,
    output logic           syncOut,
    output logic           tempWe,
    output logic           accWe,
    output logic           carryWe,
    output logic           regWe,
    output logic [FNW-1:0] aluFunc,
    output logic [1:0]     aluSrcSel,
    output logic           busy,
    output logic           done
);

    state_e         state;
    op_class_e      latCls;
    logic [FNW-1:0] latFunc;
    op_class_e      decCls;
    op_class_e      execCls;
    logic           accept;
    logic           enterExec;
    logic [2:0]     phaseNext;

    phase_counter u_phase (
        .clk     (clk),
        .rstN    (rstN),
        .phase   (phase),
        .syncOut (syncOut)
    );

    assign opReady   = (state == ST_IDLE) && (phase == PH_M2);
    assign busy      = (state != ST_IDLE);
    assign phaseNext = phase + 3'd1;
    assign accept    = opValid && opReady && (decCls != OP_NOP);

    // Decode the incoming class; unknown codes collapse to NOP.
    always_comb begin
        decCls = OP_NOP;
        case (opClass)
            OPW'(OP_LDA):   decCls = OP_LDA;
            OPW'(OP_XCH):   decCls = OP_XCH;
            OPW'(OP_ALU):   decCls = OP_ALU;
            OPW'(OP_ALUNC): decCls = OP_ALUNC;
            default:        decCls = OP_NOP;
        endcase
    end

    // X1 begins on the same edge that enters EXEC, so the X1 strobe is
    // produced from the entering transition rather than from the EXEC state.
    always_comb begin
        enterExec = 1'b0;
        execCls   = latCls;
        if (state == ST_IDLE && accept && !twoWord) begin
            enterExec = 1'b1;
            execCls   = decCls;
        end else if (state == ST_WAIT2 && phase == PH_M2) begin
            enterExec = 1'b1;
        end
    end

    // Operation FSM with registered single-cycle strobes and held ALU controls.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            latCls    <= OP_NOP;
            latFunc   <= '0;
            tempWe    <= 1'b0;
            accWe     <= 1'b0;
            carryWe   <= 1'b0;
            regWe     <= 1'b0;
            done      <= 1'b0;
            aluFunc   <= '0;
            aluSrcSel <= SRC_NONE;
        end else begin
            tempWe  <= 1'b0;
            accWe   <= 1'b0;
            carryWe <= 1'b0;
            regWe   <= 1'b0;
            done    <= 1'b0;

            if (enterExec)
                tempWe <= (execCls == OP_XCH);

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        latCls  <= decCls;
                        latFunc <= opFunc;
                        state   <= twoWord ? ST_WAIT2 : ST_EXEC;
                    end
                end
                ST_WAIT2: begin
                    if (phase == PH_M2)
                        state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (phaseNext)
                        PH_X2: begin
                            aluSrcSel <= SRC_REG;
                            if (latCls == OP_ALU || latCls == OP_ALUNC)
                                aluFunc <= latFunc;
                            else
                                aluFunc <= FNW'(FN_PASSB);
                        end
                        PH_X3: begin
                            accWe   <= 1'b1;
                            regWe   <= (latCls == OP_XCH);
                            carryWe <= (latCls == OP_ALU);
                            done    <= 1'b1;
                        end
                        PH_A1: begin
                            aluSrcSel <= SRC_NONE;
                            aluFunc   <= '0;
                            latCls    <= OP_NOP;
                            state     <= ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_temp_sequencer.sv
// Directed table-driven bench for acc_temp_sequencer.
module tb_acc_temp_sequencer;

    logic       clk;
    logic       rstN;
    logic       opValid;
    logic [2:0] opClass;
    logic [3:0] opFunc;
    logic       twoWord;
    logic       opReady;
    logic [2:0] phase;
    logic       syncOut;
    logic       tempWe;
    logic       accWe;
    logic       carryWe;
    logic       regWe;
    logic [3:0] aluFunc;
    logic [1:0] aluSrcSel;
    logic       busy;
    logic       done;

    int nTests;
    int nFail;

    acc_temp_sequencer #(.OPW(3), .FNW(4)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .opValid   (opValid),
        .opClass   (opClass),
        .opFunc    (opFunc),
        .twoWord   (twoWord),
        .opReady   (opReady),
        .phase     (phase),
        .syncOut   (syncOut),
        .tempWe    (tempWe),
        .accWe     (accWe),
        .carryWe   (carryWe),
        .regWe     (regWe),
        .aluFunc   (aluFunc),
        .aluSrcSel (aluSrcSel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Observed bundle: {busy,tempWe,accWe,carryWe,regWe,done,aluSrcSel,aluFunc}
    logic [11:0] obs;
    assign obs = {busy, tempWe, accWe, carryWe, regWe, done, aluSrcSel, aluFunc};

    function automatic logic [11:0] mk(input logic b, input logic t, input logic a,
                                       input logic c, input logic r, input logic d,
                                       input logic [1:0] s, input logic [3:0] f);
        return {b, t, a, c, r, d, s, f};
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  cls;
        logic [3:0]  fn;
        logic [11:0] e5;
        logic [11:0] e6;
        logic [11:0] e7;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ph4(input string name);
        for (int i = 0; i < 16 && phase != 3'd4; i++)
            tick();
        check({name, "_ph4"}, {9'd0, phase}, 12'd4);
    endtask

    // Issue one single-word op at phase 4 and check phases 5,6,7,0.
    task automatic run_vec(input vec_t v);
        wait_ph4(v.name);
        check({v.name, "_rdy"}, {11'd0, opReady}, 12'd1);
        opValid = 1'b1;
        opClass = v.cls;
        opFunc  = v.fn;
        twoWord = 1'b0;
        tick();
        opValid = 1'b0;
        check({v.name, "_x1"}, obs, v.e5);
        tick();
        check({v.name, "_x2"}, obs, v.e6);
        tick();
        check({v.name, "_x3"}, obs, v.e7);
        tick();
        check({v.name, "_a1"}, obs, 12'd0);
    endtask

    initial begin
        logic [2:0] expPh [10];
        int         doneCnt;

        nTests  = 0;
        nFail   = 0;
        clk     = 1'b0;
        rstN    = 1'b0;
        opValid = 1'b0;
        opClass = '0;
        opFunc  = '0;
        twoWord = 1'b0;

        tbl[0] = '{"lda",   3'd1, 4'h0, mk(1,0,0,0,0,0,2'd0,4'h0), mk(1,0,0,0,0,0,2'd1,4'hB), mk(1,0,1,0,0,1,2'd1,4'hB)};
        tbl[1] = '{"xch",   3'd2, 4'h0, mk(1,1,0,0,0,0,2'd0,4'h0), mk(1,0,0,0,0,0,2'd1,4'hB), mk(1,0,1,0,1,1,2'd1,4'hB)};
        tbl[2] = '{"alu",   3'd3, 4'h5, mk(1,0,0,0,0,0,2'd0,4'h0), mk(1,0,0,0,0,0,2'd1,4'h5), mk(1,0,1,1,0,1,2'd1,4'h5)};
        tbl[3] = '{"alunc", 3'd4, 4'h9, mk(1,0,0,0,0,0,2'd0,4'h0), mk(1,0,0,0,0,0,2'd1,4'h9), mk(1,0,1,0,0,1,2'd1,4'h9)};
        tbl[4] = '{"nop",   3'd0, 4'h3, 12'd0, 12'd0, 12'd0};
        tbl[5] = '{"unk6",  3'd6, 4'h7, 12'd0, 12'd0, 12'd0};

        // Reset state and release sequence 0,0,1..7,0
        #2;
        check("rst_obs", obs, 12'd0);
        check("rst_phase", {9'd0, phase}, 12'd0);
        check("rst_rdy", {11'd0, opReady}, 12'd0);
        tick();
        tick();
        rstN = 1'b1;
        expPh = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            check($sformatf("rel_phase%0d", i), {9'd0, phase}, {9'd0, expPh[i]});
            check($sformatf("rel_sync%0d", i), {11'd0, syncOut}, {11'd0, (expPh[i] == 3'd0)});
            check($sformatf("rel_obs%0d", i), obs, 12'd0);
        end

        // Table: consecutive machine cycles, including back-to-back ALU/ALUNC
        for (int i = 0; i < 6; i++)
            run_vec(tbl[i]);

        // Two-word ALU: quiet first cycle, execute in second
        wait_ph4("tw");
        opValid = 1'b1;
        opClass = 3'd3;
        opFunc  = 4'h3;
        twoWord = 1'b1;
        tick();
        opValid = 1'b0;
        twoWord = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("tw_wait%0d", i), obs, mk(1,0,0,0,0,0,2'd0,4'h0));
            if (phase == 3'd4)
                check("tw_rdy_low", {11'd0, opReady}, 12'd0);
            doneCnt += int'(done);
            tick();
        end
        check("tw_ph4", {9'd0, phase}, 12'd4);
        check("tw_wait_rdy", {11'd0, opReady}, 12'd0);
        check("tw_wait_ph4", obs, mk(1,0,0,0,0,0,2'd0,4'h0));
        tick();
        check("tw_x1", obs, mk(1,0,0,0,0,0,2'd0,4'h0));
        tick();
        check("tw_x2", obs, mk(1,0,0,0,0,0,2'd1,4'h3));
        tick();
        check("tw_x3", obs, mk(1,0,1,1,0,1,2'd1,4'h3));
        doneCnt += int'(done);
        tick();
        check("tw_a1", obs, 12'd0);
        doneCnt += int'(done);
        check("tw_done_once", 12'(doneCnt), 12'd1);

        // Reset at X2 during XCH
        wait_ph4("mrst");
        opValid = 1'b1;
        opClass = 3'd2;
        opFunc  = 4'h0;
        tick();
        opValid = 1'b0;
        check("mrst_x1", obs, mk(1,1,0,0,0,0,2'd0,4'h0));
        tick();
        check("mrst_x2", obs, mk(1,0,0,0,0,0,2'd1,4'hB));
        rstN = 1'b0;
        #1;
        check("mrst_obs", obs, 12'd0);
        check("mrst_phase", {9'd0, phase}, 12'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mrst_hold%0d", i), obs, 12'd0);
        end
        rstN = 1'b1;
        tick();
        check("mrst_idle", {11'd0, busy}, 12'd0);
        run_vec(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
